// File: rtl/pattern_transmitter_moore.sv
`default_nettype none
// ============================================================================
// Module      : pattern_transmitter_moore
// Description : Moore serial pattern generator. Sends PATTERN MSB-first a
//               programmable number of times with GAP idle zeros in between.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_transmitter_moore #(
    parameter int             LEN     = 6,
    parameter logic [LEN-1:0] PATTERN = 6'b011010,
    parameter int             GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] reps,
    input  logic       abort,
    output logic       q,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam int                 IDX_W      = $clog2(LEN);
    localparam logic [IDX_W-1:0]   c_IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [3:0]         c_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [3:0]       r_rep_cnt;
    logic [3:0]       w_rep_nxt;
    logic [3:0]       r_gap_cnt;
    logic [3:0]       w_gap_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rep_cnt <= 4'd0;
            r_gap_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_rep_cnt <= w_rep_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep_cnt;
        w_gap_nxt   = r_gap_cnt;
        q           = 1'b0;
        valid       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && (reps != 4'd0)) begin
                    w_rep_nxt   = reps;
                    w_idx_nxt   = c_IDX_LAST;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                q     = PATTERN[r_idx];
                valid = 1'b1;
                busy  = 1'b1;
                // Abort takes priority even over the final bit of the burst.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_rep_nxt   = 4'd0;
                end else if (r_idx != '0) begin
                    w_idx_nxt = r_idx - 1'b1;
                end else if (r_rep_cnt == 4'd1) begin
                    w_rep_nxt   = 4'd0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_rep_nxt = r_rep_cnt - 4'd1;
                    if (GAP > 0) begin
                        w_gap_nxt   = c_GAP_LOAD;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_idx_nxt = c_IDX_LAST;
                    end
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_rep_nxt   = 4'd0;
                    w_gap_nxt   = 4'd0;
                end else if (r_gap_cnt != 4'd0) begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end else begin
                    w_idx_nxt   = c_IDX_LAST;
                    w_state_nxt = S_SEND;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_transmitter_moore.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_transmitter_moore
// Description : Self-checking bench; one DUT with GAP=2 and one with GAP=0
//               share stimulus and are compared against a burst-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_transmitter_moore;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] reps;
    logic       abort;
    logic       q_g, valid_g, busy_g, done_g;
    logic       q_b, valid_b, busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    pattern_transmitter_moore #(.LEN(6), .PATTERN(6'b011010), .GAP(2)) dut_g (
        .clk(clk), .rst(rst), .start(start), .reps(reps), .abort(abort),
        .q(q_g), .valid(valid_g), .busy(busy_g), .done(done_g)
    );

    pattern_transmitter_moore #(.LEN(6), .PATTERN(6'b011010), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .reps(reps), .abort(abort),
        .q(q_b), .valid(valid_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a burst is a timeline of reps periods of (LEN + gap)
    // cycles, truncated after the last pattern bit, followed by one done cycle.
    int         gaps[2] = '{2, 0};
    bit         m_active[2];
    bit         m_done[2];
    int         m_t[2];
    int         m_total[2];
    logic [5:0] pat = 6'b011010;
    logic [5:0] det_g, det_b;
    int         hits_g, hits_b;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_done[k]   = 1'b0;
            m_t[k]      = 0;
            m_total[k]  = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_active[k] = 1'b0;
                m_done[k]   = 1'b0;
            end else if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (m_active[k]) begin
                if (abort) begin
                    m_active[k] = 1'b0;
                end else begin
                    m_t[k]++;
                    if (m_t[k] == m_total[k]) begin
                        m_active[k] = 1'b0;
                        m_done[k]   = 1'b1;
                    end
                end
            end else if (start && reps != 4'd0) begin
                m_active[k] = 1'b1;
                m_t[k]      = 0;
                m_total[k]  = int'(reps) * 6 + (int'(reps) - 1) * gaps[k];
            end
        end
    endtask

    task automatic model_compare();
        for (int k = 0; k < 2; k++) begin
            int   pos;
            logic eq, ev;
            pos = m_t[k] % (6 + gaps[k]);
            ev  = m_active[k] && (pos < 6);
            eq  = ev ? pat[5 - pos] : 1'b0;
            if (k == 0) begin
                check("model_q_g", int'(q_g), int'(eq));
                check("model_valid_g", int'(valid_g), int'(ev));
                check("model_busy_g", int'(busy_g), int'(m_active[k]));
                check("model_done_g", int'(done_g), int'(m_done[k]));
            end else begin
                check("model_q_b", int'(q_b), int'(eq));
                check("model_valid_b", int'(valid_b), int'(ev));
                check("model_busy_b", int'(busy_b), int'(m_active[k]));
                check("model_done_b", int'(done_b), int'(m_done[k]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        model_compare();
        det_g = {det_g[4:0], q_g};
        det_b = {det_b[4:0], q_b};
        if (det_g == 6'b011010) hits_g++;
        if (det_b == 6'b011010) hits_b++;
    endtask

    // Runs a 40-cycle window after one start pulse, optionally re-pulsing
    // start mid-burst, and checks aggregate burst properties.
    task automatic burst_window(input string name, input logic [3:0] r, input bit inject,
                                input int exp_busy_g, input int exp_busy_b,
                                input int exp_hits_g, input int exp_hits_b);
        int nb_g, nb_b, nd_g, nd_b, nv_b;
        nb_g = 0; nb_b = 0; nd_g = 0; nd_b = 0; nv_b = 0;
        det_g = '0; det_b = '0; hits_g = 0; hits_b = 0;
        start = 1'b1; reps = r;
        for (int i = 0; i < 40; i++) begin
            step();
            start = (inject && i == 2) ? 1'b1 : 1'b0;
            reps  = (inject && i == 2) ? 4'd3 : r;
            nb_g += int'(busy_g); nb_b += int'(busy_b);
            nd_g += int'(done_g); nd_b += int'(done_b);
            nv_b += int'(valid_b);
        end
        check({name, "_busy_g"}, nb_g, exp_busy_g);
        check({name, "_busy_b"}, nb_b, exp_busy_b);
        check({name, "_done_g"}, nd_g, 1);
        check({name, "_done_b"}, nd_b, 1);
        check({name, "_valid_b"}, nv_b, int'(r) * 6);
        check({name, "_hits_g"}, hits_g, exp_hits_g);
        check({name, "_hits_b"}, hits_b, exp_hits_b);
    endtask

    typedef struct {
        logic       start;
        logic [3:0] reps;
        logic       abort;
        logic       q, valid, busy, done;
    } vec_t;

    vec_t tbl[15];

    initial begin
        model_reset();
        det_g = '0; det_b = '0; hits_g = 0; hits_b = 0;
        rst = 1'b0; start = 1'b0; reps = 4'd0; abort = 1'b0;

        // Single burst, reps=0 request, then abort on the 4th bit (GAP=2 DUT).
        tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held for 3 cycles, then released with start low.
        for (int i = 0; i < 3; i++) step();
        check("reset_busy_g", int'(busy_g), 0);
        check("reset_q_g", int'(q_g), 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("idle_done_g", int'(done_g), 0);

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start; reps = tbl[i].reps; abort = tbl[i].abort;
            step();
            check($sformatf("tbl%0d_q", i), int'(q_g), int'(tbl[i].q));
            check($sformatf("tbl%0d_valid", i), int'(valid_g), int'(tbl[i].valid));
            check($sformatf("tbl%0d_busy", i), int'(busy_g), int'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), int'(done_g), int'(tbl[i].done));
        end
        start = 1'b0; abort = 1'b0;
        step();

        // Repeated, back-to-back and ignored mid-burst start.
        burst_window("rep3", 4'd3, 1'b0, 22, 18, 3, 3);
        burst_window("rep2", 4'd2, 1'b0, 14, 12, 2, 2);
        burst_window("inject", 4'd1, 1'b1, 6, 6, 1, 1);

        // Asynchronous reset while the GAP=2 DUT sits in its first gap cycle.
        start = 1'b1; reps = 4'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre_rst_gap_busy_g", int'(busy_g), 1);
        check("pre_rst_gap_valid_g", int'(valid_g), 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_busy_g", int'(busy_g), 0);
        check("async_rst_busy_b", int'(busy_b), 0);
        check("async_rst_valid_b", int'(valid_b), 0);
        check("async_rst_done_g", int'(done_g), 0);
        step();
        step();
        rst = 1'b1;
        step();

        // Randomized traffic against the model, including occasional reset.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            reps  = 4'($urandom_range(0, 4));
            abort = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("final_busy_g", int'(busy_g), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
